pwm_sequencer: RTL and testbench

- Single-channel PWM controller that plays a programmable table of steps. Each step has its own duty, period and repeat count.
- Software loads the step table while the block is idle, then pulses start. The block walks the table in order, optionally looping, and generates the waveform itself.
- It is used where a PWM output must change profile over time (ramps, bursts, tone sequences) without software writing per-step.

---
 rtl/pwm_seq_pkg.sv | 17 +
 rtl/pwm_seq_step_ram.sv | 34 +++
 rtl/pwm_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pwm_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM step sequencer: FSM states and step-entry field layout.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } seq_state_e;

    // A step entry packs {duty, period, repeat}; field index 0 sits at the LSBs.
    localparam int FLD_REPEAT = 0;
    localparam int FLD_PERIOD = 1;
    localparam int FLD_DUTY   = 2;
    localparam int NUM_FLDS   = 3;

endpackage

// File: rtl/pwm_seq_step_ram.sv
// Step table: DEPTH entries of packed {duty, period, repeat}, synchronous write,
// asynchronous read, cleared by reset.
module pwm_seq_step_ram
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int ENTRY_W = NUM_FLDS * WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_addr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]   i_rd_addr,
    output logic [ENTRY_W-1:0] o_rd_data
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/pwm_sequencer.sv
// Single-channel PWM that walks a table of {duty, period, repeat} steps,
// optionally looping, after a start pulse.
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_duty,
    input  logic [WIDTH-1:0] i_wr_period,
    input  logic [WIDTH-1:0] i_wr_repeat,
    input  logic [IDX_W:0]   i_num_steps,
    input  logic             i_loop,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_pwm,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_step_idx,
    output logic             o_step_done,
    output logic             o_seq_done,
    output logic             o_wr_err
);

    localparam int ENTRY_W = NUM_FLDS * WIDTH;
    localparam logic [IDX_W:0] MAX_STEPS = (IDX_W + 1)'(DEPTH);

    seq_state_e       state;
    logic [IDX_W-1:0] step_idx;
    logic [IDX_W:0]   r_num;
    logic             r_loop;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_rep;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rep_cnt;
    logic             wr_err_q;

    logic [ENTRY_W-1:0] rd_entry;
    logic [WIDTH-1:0]   rd_duty;
    logic [WIDTH-1:0]   rd_period;
    logic [WIDTH-1:0]   rd_rep;
    logic               start_go;
    logic               wr_ok;
    logic               period_end;
    logic               rep_last;
    logic               step_end;
    logic               last_step;
    seq_state_e         adv_state;
    logic [IDX_W-1:0]   adv_idx;

    assign start_go = (state == S_IDLE) && i_start && !i_abort &&
                      (i_num_steps != '0) && (i_num_steps <= MAX_STEPS);
    // A write racing an accepted start loses, so the table never changes under a running step.
    assign wr_ok = i_wr_en && (state == S_IDLE) && !start_go;

    pwm_seq_step_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (wr_ok),
        .i_wr_addr (i_wr_addr),
        .i_wr_data ({i_wr_duty, i_wr_period, i_wr_repeat}),
        .i_rd_addr (step_idx),
        .o_rd_data (rd_entry)
    );

    assign rd_duty   = rd_entry[FLD_DUTY*WIDTH +: WIDTH];
    assign rd_period = rd_entry[FLD_PERIOD*WIDTH +: WIDTH];
    assign rd_rep    = rd_entry[FLD_REPEAT*WIDTH +: WIDTH];

    assign period_end = (cnt == r_period - WIDTH'(1));
    assign rep_last   = (r_rep == '0) ? (rep_cnt == '0) : (rep_cnt == r_rep - WIDTH'(1));
    assign step_end   = (state == S_RUN) && period_end && rep_last;
    assign last_step  = ({1'b0, step_idx} == r_num - (IDX_W + 1)'(1));

    // Where the sequence goes when the current step finishes (or is skipped).
    always_comb begin
        adv_state = S_LOAD;
        adv_idx   = step_idx + IDX_W'(1);
        if (last_step) begin
            adv_idx = '0;
            if (!r_loop) begin
                adv_state = S_DONE;
                adv_idx   = step_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            step_idx <= '0;
            r_num    <= '0;
            r_loop   <= 1'b0;
            r_duty   <= '0;
            r_period <= '0;
            r_rep    <= '0;
            cnt      <= '0;
            rep_cnt  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= i_wr_en && !wr_ok;
            if (i_abort) begin
                state    <= S_IDLE;
                step_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_go) begin
                            r_num    <= i_num_steps;
                            r_loop   <= i_loop;
                            step_idx <= '0;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        r_duty   <= rd_duty;
                        r_period <= rd_period;
                        r_rep    <= rd_rep;
                        cnt      <= '0;
                        rep_cnt  <= '0;
                        if (rd_period == '0) begin
                            state    <= adv_state;
                            step_idx <= adv_idx;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (period_end) begin
                            cnt     <= '0;
                            rep_cnt <= rep_cnt + WIDTH'(1);
                            if (rep_last) begin
                                state    <= adv_state;
                                step_idx <= adv_idx;
                            end
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Outputs are decodes of registered state only (the table read is from a register file).
    assign o_pwm       = (state == S_RUN) && ((r_duty >= r_period) || (cnt < r_duty));
    assign o_busy      = (state != S_IDLE);
    assign o_step_idx  = step_idx;
    assign o_step_done = step_end || ((state == S_LOAD) && (rd_period == '0));
    assign o_seq_done  = (state == S_DONE);
    assign o_wr_err    = wr_err_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: per-cycle expected traces written by hand.
module tb_pwm_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [WIDTH-1:0] wr_duty;
    logic [WIDTH-1:0] wr_period;
    logic [WIDTH-1:0] wr_repeat;
    logic [IDX_W:0]   num_steps;
    logic             loop_en;
    logic             start;
    logic             abort;
    logic             pwm;
    logic             busy;
    logic [IDX_W-1:0] step_idx;
    logic             step_done;
    logic             seq_done;
    logic             wr_err;

    int checks = 0;
    int errors = 0;

    pwm_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_duty   (wr_duty),
        .i_wr_period (wr_period),
        .i_wr_repeat (wr_repeat),
        .i_num_steps (num_steps),
        .i_loop      (loop_en),
        .i_start     (start),
        .i_abort     (abort),
        .o_pwm       (pwm),
        .o_busy      (busy),
        .o_step_idx  (step_idx),
        .o_step_done (step_done),
        .o_seq_done  (seq_done),
        .o_wr_err    (wr_err)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- drivers ----------------
    // Inputs change and outputs are sampled at the negedge; the DUT acts on posedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr_entry(input int addr, input int duty, input int period, input int rep);
        wr_en     = 1'b1;
        wr_addr   = IDX_W'(addr);
        wr_duty   = WIDTH'(duty);
        wr_period = WIDTH'(period);
        wr_repeat = WIDTH'(rep);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_seq(input int n, input logic lp);
        num_steps = (IDX_W + 1)'(n);
        loop_en   = lp;
        start     = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Trace chars -> expected {pwm, busy, step_done, seq_done}:
    // L load, K skipped load, 0/1 run, a/b last run cycle with pwm 0/1, D done, I idle.
    function automatic logic [3:0] exp_of(input byte c);
        case (c)
            "L", "0": return 4'b0100;
            "1":      return 4'b1100;
            "a", "K": return 4'b0110;
            "b":      return 4'b1110;
            "D":      return 4'b0101;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input byte c);
        byte d;
        d = c - 8'd48;
        return d[IDX_W-1:0];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        tick();
        checks++;
        if ({pwm, busy, step_idx, step_done, seq_done, wr_err} !== '0) begin
            errors++;
            $display("FAIL reset_held: got %b, expected all zero",
                     {pwm, busy, step_idx, step_done, seq_done, wr_err});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({pwm, busy, step_idx, step_done, seq_done, wr_err} !== '0) begin
            errors++;
            $display("FAIL reset_released: got %b, expected all zero",
                     {pwm, busy, step_idx, step_done, seq_done, wr_err});
        end
    endtask

    task automatic test_single();
        string tr = "L11001100110aDI";
        wr_entry(0, 2, 4, 3);
        start_seq(1, 1'b0);
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i]) || step_idx !== '0) begin
                errors++;
                $display("FAIL single[%0d]: got pwm/busy/sd/qd=%b idx=%0d, expected %b idx=0",
                         i, {pwm, busy, step_done, seq_done}, step_idx, exp_of(tr[i]));
            end
            tick();
        end
    endtask

    task automatic test_multi();
        string tr = "L000aL111bL111bDI";
        string ix = "00000111112222222";
        wr_entry(0, 0, 4, 1);
        wr_entry(1, 4, 4, 1);
        wr_entry(2, 5, 4, 1);
        start_seq(3, 1'b0);
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i]) || step_idx !== idx_of(ix[i])) begin
                errors++;
                $display("FAIL multi[%0d]: got pwm/busy/sd/qd=%b idx=%0d, expected %b idx=%0d",
                         i, {pwm, busy, step_done, seq_done}, step_idx, exp_of(tr[i]), idx_of(ix[i]));
            end
            tick();
        end
    endtask

    task automatic test_loop_abort();
        string tr = "L101aKL101aKL10";
        string ix = "000001000001000";
        wr_entry(0, 1, 2, 2);
        wr_entry(1, 0, 0, 1);
        start_seq(2, 1'b1);
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i]) || step_idx !== idx_of(ix[i])) begin
                errors++;
                $display("FAIL loop[%0d]: got pwm/busy/sd/qd=%b idx=%0d, expected %b idx=%0d",
                         i, {pwm, busy, step_done, seq_done}, step_idx, exp_of(tr[i]), idx_of(ix[i]));
            end
            tick();
        end
        // Second repeat of step 0 is running: pwm high, then abort.
        checks++;
        if ({pwm, busy} !== 2'b11) begin
            errors++;
            $display("FAIL pre_abort: got pwm/busy=%b, expected 11", {pwm, busy});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({pwm, busy, seq_done} !== 3'b000) begin
                errors++;
                $display("FAIL post_abort[%0d]: got pwm/busy/qd=%b, expected 000",
                         i, {pwm, busy, seq_done});
            end
            tick();
        end
    endtask

    task automatic test_write_protect();
        string tr = "L101aDI";
        start_seq(1, 1'b0);
        tick();
        tick();
        wr_en     = 1'b1;
        wr_addr   = '0;
        wr_duty   = 8'd2;
        wr_period = 8'd4;
        wr_repeat = 8'd1;
        tick();
        wr_en = 1'b0;
        checks++;
        if ({wr_err, busy} !== 2'b11) begin
            errors++;
            $display("FAIL wr_while_run: got wr_err/busy=%b, expected 11", {wr_err, busy});
        end
        tick();
        checks++;
        if (wr_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_err_pulse: got %b, expected 0", wr_err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        // Readback run: entry 0 must still be {1,2,2}.
        start_seq(1, 1'b0);
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i])) begin
                errors++;
                $display("FAIL readback[%0d]: got pwm/busy/sd/qd=%b, expected %b",
                         i, {pwm, busy, step_done, seq_done}, exp_of(tr[i]));
            end
            tick();
        end
        // Write and start in the same idle cycle: start wins.
        wr_en     = 1'b1;
        wr_addr   = '0;
        wr_duty   = 8'd3;
        wr_period = 8'd3;
        wr_repeat = 8'd1;
        num_steps = 4'd1;
        loop_en   = 1'b0;
        start     = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        checks++;
        if ({wr_err, busy} !== 2'b11) begin
            errors++;
            $display("FAIL wr_with_start: got wr_err/busy=%b, expected 11", {wr_err, busy});
        end
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i])) begin
                errors++;
                $display("FAIL start_wins[%0d]: got pwm/busy/sd/qd=%b, expected %b",
                         i, {pwm, busy, step_done, seq_done}, exp_of(tr[i]));
            end
            tick();
        end
    endtask

    task automatic test_invalid_start();
        start_seq(0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_n0: got busy=%b, expected 0", busy);
        end
        start_seq(DEPTH + 1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_n9: got busy=%b, expected 0", busy);
        end
        abort = 1'b1;
        start_seq(1, 1'b0);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort: got busy=%b, expected 0", busy);
        end
        tick();
        checks++;
        if ({pwm, busy} !== 2'b00) begin
            errors++;
            $display("FAIL still_idle: got pwm/busy=%b, expected 00", {pwm, busy});
        end
    endtask

    task automatic test_reset_mid();
        string tr = "KKDI";
        string ix = "0111";
        wr_entry(1, 3, 4, 1);
        start_seq(2, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if ({pwm, busy, step_idx} !== {2'b11, 3'd1}) begin
            errors++;
            $display("FAIL pre_reset: got pwm/busy/idx=%b, expected 11001", {pwm, busy, step_idx});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pwm, busy, step_idx} !== '0) begin
            errors++;
            $display("FAIL async_reset: got pwm/busy/idx=%b, expected 00000", {pwm, busy, step_idx});
        end
        tick();
        rst = 1'b0;
        start_seq(2, 1'b0);
        for (int i = 0; i < tr.len(); i++) begin
            checks++;
            if ({pwm, busy, step_done, seq_done} !== exp_of(tr[i]) || step_idx !== idx_of(ix[i])) begin
                errors++;
                $display("FAIL cleared_table[%0d]: got pwm/busy/sd/qd=%b idx=%0d, expected %b idx=%0d",
                         i, {pwm, busy, step_done, seq_done}, step_idx, exp_of(tr[i]), idx_of(ix[i]));
            end
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_duty   = '0;
        wr_period = '0;
        wr_repeat = '0;
        num_steps = '0;
        loop_en   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_loop_abort();
        test_write_protect();
        test_invalid_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
